// File: rtl/i2s_receiver.sv
// i2s_receiver: mclk-domain I2S record receiver pairing left/right words into a show-ahead FIFO.
module i2s_receiver #(
  parameter int SAMPLE_BITS = 16,
  parameter int FIFO_DEPTH  = 4
) (
  input  logic                          mclk,
  input  logic                          rst_n,
  input  logic                          audio_I2S_bclk,
  input  logic                          audio_I2S_reclrc,
  input  logic                          audio_I2S_recdat,
  output logic [SAMPLE_BITS-1:0]        left_sample,
  output logic [SAMPLE_BITS-1:0]        right_sample,
  output logic                          sample_valid,
  input  logic                          sample_ready,
  output logic [$clog2(FIFO_DEPTH):0]   fifo_level,
  output logic                          overflow,
  output logic                          frame_error,
  input  logic                          clear_errors
);
  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int CW = $clog2(SAMPLE_BITS + 2);
  localparam logic [CW-1:0] CMAX  = CW'(SAMPLE_BITS + 1);
  localparam logic [CW-1:0] CFULL = CW'(SAMPLE_BITS);
  localparam logic [AW:0]   DEPTH = (AW + 1)'(FIFO_DEPTH);

  typedef enum logic {ALIGN, RECEIVE} state_t;
  state_t state, state_nxt;

  logic [2:0] bclk_q;
  logic [1:0] lr_q, dat_q;
  logic rise, lr_chg, lr_prev;
  logic [SAMPLE_BITS-1:0] shreg, word_nxt, done_word, left_hold;
  logic [CW-1:0] cnt, cnt_inc;
  logic done, done_ok, done_right, pend;
  logic push_req, push, pop, full, ovf_ev, ferr_ev;
  logic [2*SAMPLE_BITS-1:0] push_data;
  logic [2*SAMPLE_BITS-1:0] mem [FIFO_DEPTH];
  logic [AW-1:0] wr_ptr, rd_ptr;

  // The bit sampled on an LRCLK-change rise is the LSB of the word just ending.
  assign rise     = bclk_q[1] & ~bclk_q[2];
  assign lr_chg   = rise & (lr_q[1] != lr_prev);
  assign word_nxt = {shreg[SAMPLE_BITS-2:0], dat_q[1]};
  assign cnt_inc  = (cnt == CMAX) ? cnt : cnt + 1'b1;

  always_comb state_nxt = (state == ALIGN && lr_chg) ? RECEIVE : state;

  always_ff @(posedge mclk or negedge rst_n)
    if (!rst_n) state <= ALIGN;
    else        state <= state_nxt;

  always_ff @(posedge mclk or negedge rst_n) begin
    if (!rst_n) begin
      bclk_q     <= '0;
      lr_q       <= '0;
      dat_q      <= '0;
      lr_prev    <= 1'b0;
      shreg      <= '0;
      cnt        <= '0;
      done       <= 1'b0;
      done_ok    <= 1'b0;
      done_right <= 1'b0;
      done_word  <= '0;
    end else begin
      bclk_q <= {bclk_q[1:0], audio_I2S_bclk};
      lr_q   <= {lr_q[0], audio_I2S_reclrc};
      dat_q  <= {dat_q[0], audio_I2S_recdat};
      done   <= lr_chg && state == RECEIVE;
      if (rise) begin
        shreg   <= word_nxt;
        lr_prev <= lr_q[1];
        cnt     <= lr_chg ? '0 : cnt_inc;
      end
      if (lr_chg) begin
        done_word  <= word_nxt;
        done_ok    <= cnt_inc == CFULL;
        done_right <= lr_prev;
      end
    end
  end

  always_ff @(posedge mclk or negedge rst_n) begin
    if (!rst_n) begin
      pend      <= 1'b0;
      left_hold <= '0;
      push_req  <= 1'b0;
      push_data <= '0;
    end else begin
      push_req <= 1'b0;
      if (done) begin
        if (!done_ok) pend <= 1'b0;
        else if (!done_right) begin
          left_hold <= done_word;
          pend      <= 1'b1;
        end else if (pend) begin
          push_req  <= 1'b1;
          push_data <= {left_hold, done_word};
          pend      <= 1'b0;
        end
      end
    end
  end

  assign sample_valid = fifo_level != '0;
  assign full         = fifo_level == DEPTH;
  assign pop          = sample_valid & sample_ready;
  assign push         = push_req & (~full | pop);
  assign ovf_ev       = push_req & full & ~pop;
  assign ferr_ev      = done & ~done_ok;
  assign {left_sample, right_sample} = sample_valid ? mem[rd_ptr] : '0;

  always_ff @(posedge mclk)
    if (push) mem[wr_ptr] <= push_data;

  always_ff @(posedge mclk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr      <= '0;
      rd_ptr      <= '0;
      fifo_level  <= '0;
      overflow    <= 1'b0;
      frame_error <= 1'b0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      fifo_level  <= fifo_level + (AW + 1)'(push) - (AW + 1)'(pop);
      overflow    <= ovf_ev | (overflow & ~clear_errors);
      frame_error <= ferr_ev | (frame_error & ~clear_errors);
    end
  end
endmodule

// File: tb/tb_i2s_receiver.sv
// tb_i2s_receiver: table-driven, directed and randomized checks against a half-frame level model.
module tb_i2s_receiver;
  logic mclk = 0, rst_n = 0, bclk = 0, lrc = 0, dat = 0;
  logic [15:0] left_sample, right_sample;
  logic sample_valid, sample_ready = 0, overflow, frame_error, clear_errors = 0;
  logic [2:0] fifo_level;
  int checks = 0, errors = 0;

  i2s_receiver #(.SAMPLE_BITS(16), .FIFO_DEPTH(4)) dut (
    .mclk(mclk), .rst_n(rst_n), .audio_I2S_bclk(bclk), .audio_I2S_reclrc(lrc),
    .audio_I2S_recdat(dat), .left_sample(left_sample), .right_sample(right_sample),
    .sample_valid(sample_valid), .sample_ready(sample_ready), .fifo_level(fifo_level),
    .overflow(overflow), .frame_error(frame_error), .clear_errors(clear_errors)
  );

  always #5 mclk = ~mclk;

  initial begin
    #3_000_000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1);
  end

  typedef struct {bit ch; logic [15:0] v; int n;} hf_t;
  typedef struct {logic [15:0] l, r; int nl; logic ev; logic [15:0] el, er; logic ef;} vec_t;
  hf_t hfs[$];
  logic [31:0] exp_q[$];
  logic exp_ferr, exp_ovf, last_bit;
  logic [15:0] pl[6], pr[6];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  function automatic bit wbit(input hf_t h, input int j);
    return (j < 16) ? h.v[15-j] : 1'b0;
  endfunction

  task automatic add(input bit ch, input logic [15:0] v, input int n);
    hf_t h;
    h.ch = ch; h.v = v; h.n = n;
    hfs.push_back(h);
  endtask

  task automatic do_reset();
    bclk = 0; lrc = 0; dat = 0; sample_ready = 0; clear_errors = 0;
    rst_n = 0;
    repeat (3) @(negedge mclk);
    rst_n = 1;
    repeat (2) @(negedge mclk);
    hfs.delete();
  endtask

  task automatic slot(input bit lr, input bit d);
    bclk = 0; lrc = lr; dat = d;
    repeat (8) @(negedge mclk);
    bclk = 1;
    repeat (8) @(negedge mclk);
  endtask

  // Transmitter: each half-frame's first slot carries the previous word's LSB.
  task automatic send_hfs();
    bit lb = 0;
    foreach (hfs[k]) begin
      for (int s = 0; s < hfs[k].n; s++) slot(hfs[k].ch, s == 0 ? lb : wbit(hfs[k], s - 1));
      lb = wbit(hfs[k], hfs[k].n - 1);
    end
    last_bit = lb;
    repeat (4) @(negedge mclk);
  endtask

  // Reference: every LRCLK change after the first aligning one completes the preceding half-frame.
  task automatic model();
    bit prev = 0, aligned = 0, pend = 0;
    logic [15:0] lh = '0;
    exp_q.delete(); exp_ferr = 0; exp_ovf = 0;
    foreach (hfs[k]) begin
      if (hfs[k].ch != prev) begin
        if (aligned) begin
          if (hfs[k-1].n != 16) begin exp_ferr = 1; pend = 0; end
          else if (!hfs[k-1].ch) begin lh = hfs[k-1].v; pend = 1; end
          else if (pend) begin
            if (exp_q.size() < 4) exp_q.push_back({lh, hfs[k-1].v});
            else exp_ovf = 1;
            pend = 0;
          end
        end else aligned = 1;
        prev = hfs[k].ch;
      end
    end
  endtask

  task automatic pop_check(input string name, input logic [15:0] l, input logic [15:0] r);
    chk({name, " valid"}, {31'd0, sample_valid}, 32'd1);
    chk({name, " left"}, {16'd0, left_sample}, {16'd0, l});
    chk({name, " right"}, {16'd0, right_sample}, {16'd0, r});
    sample_ready = 1;
    @(negedge mclk);
    sample_ready = 0;
    @(negedge mclk);
  endtask

  task automatic drain(input string name);
    chk({name, " level"}, {29'd0, fifo_level}, exp_q.size());
    chk({name, " ferr"}, {31'd0, frame_error}, {31'd0, exp_ferr});
    chk({name, " ovf"}, {31'd0, overflow}, {31'd0, exp_ovf});
    foreach (exp_q[i]) pop_check(name, exp_q[i][31:16], exp_q[i][15:0]);
    chk({name, " empty"}, {31'd0, sample_valid}, 32'd0);
  endtask

  initial begin
    vec_t tbl[6];
    tbl[0] = '{16'h1234, 16'hFEDC, 16, 1'b1, 16'h1234, 16'hFEDC, 1'b0};
    tbl[1] = '{16'h8000, 16'h7FFF, 16, 1'b1, 16'h8000, 16'h7FFF, 1'b0};
    tbl[2] = '{16'h0000, 16'hFFFF, 16, 1'b1, 16'h0000, 16'hFFFF, 1'b0};
    tbl[3] = '{16'hA5A5, 16'h5A5A, 16, 1'b1, 16'hA5A5, 16'h5A5A, 1'b0};
    tbl[4] = '{16'h1234, 16'h5678, 15, 1'b0, 16'h0000, 16'h0000, 1'b1};
    tbl[5] = '{16'hCAFE, 16'hBEEF, 17, 1'b0, 16'h0000, 16'h0000, 1'b1};

    do_reset();
    chk("reset valid", {31'd0, sample_valid}, 32'd0);
    chk("reset level", {29'd0, fifo_level}, 32'd0);
    chk("reset left", {16'd0, left_sample}, 32'd0);
    chk("reset right", {16'd0, right_sample}, 32'd0);
    chk("reset flags", {30'd0, overflow, frame_error}, 32'd0);

    foreach (tbl[i]) begin
      do_reset();
      add(0, 16'h0F0F, 16); add(1, 16'hF0F0, 16);
      add(0, tbl[i].l, tbl[i].nl); add(1, tbl[i].r, 16); add(0, 16'h0, 1);
      send_hfs();
      chk($sformatf("vec%0d valid", i), {31'd0, sample_valid}, {31'd0, tbl[i].ev});
      chk($sformatf("vec%0d level", i), {29'd0, fifo_level}, {31'd0, tbl[i].ev});
      chk($sformatf("vec%0d left", i), {16'd0, left_sample}, {16'd0, tbl[i].el});
      chk($sformatf("vec%0d right", i), {16'd0, right_sample}, {16'd0, tbl[i].er});
      chk($sformatf("vec%0d ferr", i), {31'd0, frame_error}, {31'd0, tbl[i].ef});
    end

    do_reset();
    add(0, 16'h0F0F, 16); add(1, 16'hF0F0, 16);
    for (int p = 0; p < 5; p++) begin
      add(0, 16'h1100 + 16'(p), 16); add(1, 16'h2200 + 16'(p), 16);
    end
    add(0, 16'h0, 1);
    model();
    send_hfs();
    chk("full level", {29'd0, fifo_level}, 32'd4);
    chk("full ovf", {31'd0, overflow}, 32'd1);
    drain("full");
    sample_ready = 1;
    repeat (5) @(negedge mclk);
    sample_ready = 0;
    chk("empty ready level", {29'd0, fifo_level}, 32'd0);
    clear_errors = 1;
    @(negedge mclk);
    clear_errors = 0;
    @(negedge mclk);
    chk("ovf cleared", {31'd0, overflow}, 32'd0);

    do_reset();
    add(0, 16'h0F0F, 16); add(1, 16'hF0F0, 16);
    add(0, 16'h1357, 15); add(1, 16'h2468, 16);
    add(0, 16'h8000, 16); add(1, 16'h7FFF, 16); add(0, 16'h0, 1);
    model();
    send_hfs();
    drain("short");

    do_reset();
    add(0, 16'h0F0F, 16); add(1, 16'hF0F0, 16);
    add(0, 16'h4321, 16); add(1, 16'h8765, 16); add(0, 16'h1111, 16);
    send_hfs();
    slot(1, last_bit);
    for (int s = 0; s < 7; s++) slot(1, s[0]);
    chk("pre-reset valid", {31'd0, sample_valid}, 32'd1);
    chk("pre-reset left", {16'd0, left_sample}, 32'h4321);
    bclk = 0;
    rst_n = 0;
    #1;
    chk("async reset valid", {31'd0, sample_valid}, 32'd0);
    chk("async reset level", {29'd0, fifo_level}, 32'd0);
    chk("async reset data", {left_sample, right_sample}, 32'd0);
    chk("async reset flags", {30'd0, overflow, frame_error}, 32'd0);
    repeat (3) @(negedge mclk);
    rst_n = 1;
    repeat (2) @(negedge mclk);
    hfs.delete();
    add(1, 16'h5555, 8); add(0, 16'hABCD, 16); add(1, 16'hDCBA, 16); add(0, 16'h0, 1);
    model();
    send_hfs();
    drain("midword reset");

    do_reset();
    add(0, 16'h0F0F, 16); add(1, 16'hF0F0, 16);
    for (int p = 0; p < 5; p++) begin
      pl[p] = 16'h3300 + 16'(p); pr[p] = 16'h4400 + 16'(p);
      add(0, pl[p], 16); add(1, pr[p], 16);
    end
    send_hfs();
    chk("pushpop pre level", {29'd0, fifo_level}, 32'd4);
    bclk = 0; lrc = 0; dat = last_bit;
    repeat (8) @(negedge mclk);
    bclk = 1;
    repeat (4) @(negedge mclk);
    sample_ready = 1;
    @(negedge mclk);
    sample_ready = 0;
    repeat (4) @(negedge mclk);
    chk("pushpop ovf", {31'd0, overflow}, 32'd0);
    chk("pushpop level", {29'd0, fifo_level}, 32'd4);
    for (int p = 1; p < 5; p++) pop_check("pushpop", pl[p], pr[p]);

    do_reset();
    add(0, 16'h0F0F, 16); add(1, 16'hF0F0, 16); add(0, 16'h9999, 15);
    send_hfs();
    bclk = 0; lrc = 1; dat = last_bit;
    repeat (8) @(negedge mclk);
    bclk = 1;
    repeat (3) @(negedge mclk);
    clear_errors = 1;
    @(negedge mclk);
    clear_errors = 0;
    repeat (4) @(negedge mclk);
    chk("clear vs ferr", {31'd0, frame_error}, 32'd1);
    clear_errors = 1;
    @(negedge mclk);
    clear_errors = 0;
    @(negedge mclk);
    chk("ferr cleared", {31'd0, frame_error}, 32'd0);

    for (int it = 0; it < 6; it++) begin
      do_reset();
      add(0, 16'(($urandom)), 16); add(1, 16'(($urandom)), 16);
      for (int p = 0; p < int'($urandom_range(2, 6)); p++) begin
        add(0, 16'($urandom), ($urandom_range(0, 4) == 0) ? 15 + 2 * int'($urandom_range(0, 1)) : 16);
        add(1, 16'($urandom), ($urandom_range(0, 4) == 0) ? 15 + 2 * int'($urandom_range(0, 1)) : 16);
      end
      add(0, 16'h0, 1);
      model();
      send_hfs();
      drain($sformatf("rand%0d", it));
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule

// File: doc/i2s_receiver.md
I2S_RECEIVER -- requirements
Module: i2s_receiver

Interface
REQ-001 SHALL have parameter SAMPLE_BITS, default 16, bits per channel word, which is also the bclk periods per LRCLK half-period.
REQ-002 SHALL have parameter FIFO_DEPTH, default 4, stereo-pair FIFO entries (power of 2, >=2).
REQ-003 SHALL have ports, one per line:
- mclk  input  1  master clock; the only clock; all logic on rising edge
- rst_n  input  1  asynchronous active-low reset
- audio_I2S_bclk  input  1  bit clock from codec/master, asynchronous to mclk
- audio_I2S_reclrc  input  1  record word select; low = left, high = right
- audio_I2S_recdat  input  1  record serial data, MSB first
- left_sample  output  SAMPLE_BITS  signed left word at FIFO head
- right_sample  output  SAMPLE_BITS  signed right word at FIFO head
- sample_valid  output  1  FIFO non-empty
- sample_ready  input  1  consumer accepts head pair
- fifo_level  output  $clog2(FIFO_DEPTH)+1  entries held
- overflow  output  1  sticky: pair dropped on full FIFO
- frame_error  output  1  sticky: word with wrong bit count seen
- clear_errors  input  1  one-cycle pulse, clears sticky flags

Function
REQ-004 SHALL pass bclk, reclrc, recdat each through a 2-flop synchronizer in mclk; bclk rising edge detected from stage-2 vs stage-3 of bclk.
REQ-005 SHALL support bclk high and low phases each >= 4 mclk cycles; behaviour below that is undefined.
REQ-006 On each detected bclk rise, SHALL shift synchronized recdat into a SAMPLE_BITS shift register (MSB first) and increment a bit counter (saturating at SAMPLE_BITS+1).
REQ-007 SHALL implement states ALIGN and RECEIVE; reset enters ALIGN.
REQ-008 ALIGN: on first bclk rise where reclrc differs from its stored previous level, SHALL clear bit counter, discard shifted data, enter RECEIVE.
REQ-009 RECEIVE: bclk rise where reclrc differs from stored level (LSB coincides with LRCLK change, I2S one-bit delay) SHALL complete the word for the previous (stored) channel, then clear counter.
REQ-010 A completed word with bit count == SAMPLE_BITS SHALL be accepted; any other count SHALL set frame_error, discard the word, clear left-pending, remain in RECEIVE.
REQ-011 Accepted left word SHALL be held and set left-pending (a newer left word overwrites it).
REQ-012 Accepted right word with left-pending SHALL push {left,right} to the FIFO and clear left-pending; right word without left-pending SHALL be discarded.
REQ-013 Latency: if mclk edge N first captures bclk high in stage 1, the word completes at edge N+3 and a pushed pair appears at FIFO head (sample_valid high if empty) at edge N+4.
REQ-014 FIFO SHALL be show-ahead: left_sample/right_sample show head whenever sample_valid=1; pop on sample_valid && sample_ready in the same cycle.
REQ-015 Push when full without pop SHALL drop the new pair and set overflow; push and pop same cycle when full SHALL succeed; push and pop when empty: push succeeds, no pop occurs.
REQ-016 Pointers SHALL wrap modulo FIFO_DEPTH; fifo_level SHALL equal pushes minus pops, range 0..FIFO_DEPTH.
REQ-017 clear_errors SHALL clear overflow and frame_error; an error event in the same cycle SHALL win (flag set).
REQ-018 sample_ready while sample_valid=0 SHALL have no effect.

Reset
REQ-019 rst_n low SHALL asynchronously force: state ALIGN, synchronizers 0, counters 0, FIFO empty, left-pending 0, sample_valid 0, fifo_level 0, left_sample 0, right_sample 0, overflow 0, frame_error 0.
REQ-020 Reset mid-word SHALL discard partial data; after release the first reclrc transition only aligns (no word output).

Verification
REQ-021 Reset, mclk/bclk=16, send left 0x1234 right 0xFEDC (I2S timing) -> first frame aligns only; next frame gives sample_valid=1, left_sample=0x1234, right_sample=0xFEDC, fifo_level=1.
REQ-022 sample_ready=0, stream 5 pairs, FIFO_DEPTH=4 -> fifo_level=4, overflow=1, head is first pair; pop all gives pairs 1-4 in order.
REQ-023 Shorten one left half-frame to 15 bclks -> frame_error=1, that pair dropped, following pair 0x8000/0x7FFF received intact.
REQ-024 Assert rst_n low at bit 7 of right word -> all outputs 0 immediately; after release next output pair is first complete frame after alignment.
REQ-025 Full FIFO, sample_ready=1 in cycle of push -> no overflow, fifo_level stays 4; clear_errors pulse same cycle as frame error -> frame_error stays 1.
